// File: rtl/mpu6050_sequencer.sv
// mpu6050_sequencer: periodically reads six consecutive MPU6050 registers
// through a single-register I2C master and publishes three signed 16-bit
// axis words with a one-cycle frame strobe.
`timescale 1ns/1ps
module mpu6050_sequencer #(
  parameter int unsigned SAMPLE_PERIOD  = 500_000,
  parameter int unsigned TIMEOUT_CYCLES = 100_000,
  parameter logic [7:0]  ACCEL_BASE     = 8'h3B,
  parameter logic [7:0]  GYRO_BASE      = 8'h43
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sel_gyro,
  input  logic        i2c_ready,
  input  logic [7:0]  i2c_data,
  input  logic        i2c_data_valid,
  output logic        i2c_start,
  output logic [7:0]  i2c_reg_addr,
  output logic [15:0] axis_x,
  output logic [15:0] axis_y,
  output logic [15:0] axis_z,
  output logic        frame_is_gyro,
  output logic        frame_valid,
  output logic        busy,
  output logic        timeout_err,
  output logic        overrun
);

  localparam int unsigned PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DATA, DONE, WAIT_TICK} state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic          sel_q, sel_d;
  logic [PW-1:0] per_cnt_q, per_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  // Only bytes 0..4 need shadowing; byte 5 goes straight into axis_z.
  logic [7:0]    shadow_q [5];
  logic [7:0]    shadow_d [5];
  logic [15:0]   axis_x_q, axis_x_d, axis_y_q, axis_y_d, axis_z_q, axis_z_d;
  logic          frame_is_gyro_q, frame_is_gyro_d;
  logic          overrun_q, overrun_d;

  logic tick, in_frame, got_byte, tmo_hit;

  // Shared status terms used by both the FSM and the datapath.
  always_comb begin
    tick     = (state_q != IDLE) && (per_cnt_q == PERIOD_LAST);
    in_frame = (state_q == ISSUE) || (state_q == WAIT_DATA) || (state_q == DONE);
    got_byte = (state_q == WAIT_DATA) && i2c_data_valid;
    // A byte arriving in the same cycle as the deadline still counts.
    tmo_hit  = (state_q == WAIT_DATA) && !i2c_data_valid && (tmo_cnt_q == TIMEOUT_LAST);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; dropping enable abandons everything.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      state_d = ISSUE;
        ISSUE:     if (i2c_ready) state_d = WAIT_DATA;
        WAIT_DATA: begin
          if (i2c_data_valid) state_d = (idx_q == 3'd5) ? DONE : ISSUE;
          else if (tmo_hit)   state_d = WAIT_TICK;
        end
        DONE:      state_d = WAIT_TICK;
        WAIT_TICK: if (tick) state_d = ISSUE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // FSM outputs; start is combinational so it lands in the ready cycle.
  always_comb begin
    i2c_start   = (state_q == ISSUE) && i2c_ready && enable;
    busy        = in_frame;
    frame_valid = (state_q == DONE);
    timeout_err = tmo_hit && enable;
  end

  // Datapath next values: index, select latch, counters, shadow and axis words.
  always_comb begin
    idx_d           = idx_q;
    sel_d           = sel_q;
    shadow_d        = shadow_q;
    axis_x_d        = axis_x_q;
    axis_y_d        = axis_y_q;
    axis_z_d        = axis_z_q;
    frame_is_gyro_d = frame_is_gyro_q;
    overrun_d       = overrun_q | (tick && in_frame);
    per_cnt_d       = (state_q == IDLE || per_cnt_q == PERIOD_LAST) ? '0 : per_cnt_q + PW'(1);
    tmo_cnt_d       = tmo_cnt_q;

    if (i2c_start)                  tmo_cnt_d = '0;
    else if (state_q == WAIT_DATA)  tmo_cnt_d = tmo_cnt_q + TW'(1);

    if (enable) begin
      if (state_q == IDLE || (state_q == WAIT_TICK && tick)) begin
        sel_d = sel_gyro;
        idx_d = 3'd0;
      end
      if (got_byte) begin
        if (idx_q == 3'd5) begin
          // Final byte: publish the whole frame so the words change with frame_valid.
          axis_x_d        = {shadow_q[0], shadow_q[1]};
          axis_y_d        = {shadow_q[2], shadow_q[3]};
          axis_z_d        = {shadow_q[4], i2c_data};
          frame_is_gyro_d = sel_q;
        end else begin
          for (int i = 0; i < 5; i++) begin
            if (idx_q == 3'(i)) shadow_d[i] = i2c_data;
          end
          idx_d = idx_q + 3'd1;
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q           <= '0;
      sel_q           <= 1'b0;
      per_cnt_q       <= '0;
      tmo_cnt_q       <= '0;
      for (int i = 0; i < 5; i++) shadow_q[i] <= '0;
      axis_x_q        <= '0;
      axis_y_q        <= '0;
      axis_z_q        <= '0;
      frame_is_gyro_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      idx_q           <= idx_d;
      sel_q           <= sel_d;
      per_cnt_q       <= per_cnt_d;
      tmo_cnt_q       <= tmo_cnt_d;
      for (int i = 0; i < 5; i++) shadow_q[i] <= shadow_d[i];
      axis_x_q        <= axis_x_d;
      axis_y_q        <= axis_y_d;
      axis_z_q        <= axis_z_d;
      frame_is_gyro_q <= frame_is_gyro_d;
      overrun_q       <= overrun_d;
    end
  end

  // Register address follows the latched source and current byte index.
  always_comb begin
    i2c_reg_addr  = (sel_q ? GYRO_BASE : ACCEL_BASE) + {5'b0, idx_q};
    axis_x        = axis_x_q;
    axis_y        = axis_y_q;
    axis_z        = axis_z_q;
    frame_is_gyro = frame_is_gyro_q;
    overrun       = overrun_q;
  end

endmodule

// File: tb/tb_mpu6050_sequencer.sv
// Testbench for mpu6050_sequencer: table-driven frames plus timeout,
// overrun, abort and asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_mpu6050_sequencer;

  localparam int SP = 200;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        reset, enable, sel_gyro, i2c_ready, i2c_data_valid;
  logic [7:0]  i2c_data;
  logic        i2c_start, frame_is_gyro, frame_valid, busy, timeout_err, overrun;
  logic [7:0]  i2c_reg_addr;
  logic [15:0] axis_x, axis_y, axis_z;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mpu6050_sequencer #(
    .SAMPLE_PERIOD (SP),
    .TIMEOUT_CYCLES(TO),
    .ACCEL_BASE    (8'h3B),
    .GYRO_BASE     (8'h43)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .sel_gyro      (sel_gyro),
    .i2c_ready     (i2c_ready),
    .i2c_data      (i2c_data),
    .i2c_data_valid(i2c_data_valid),
    .i2c_start     (i2c_start),
    .i2c_reg_addr  (i2c_reg_addr),
    .axis_x        (axis_x),
    .axis_y        (axis_y),
    .axis_z        (axis_z),
    .frame_is_gyro (frame_is_gyro),
    .frame_valid   (frame_valid),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .overrun       (overrun)
  );

  // Master-model state and event logs
  logic [7:0]  mem [256];
  int          lat = 10;
  int          withhold_idx = -1;
  int          start_cyc[$];
  logic [7:0]  start_addr[$];
  int          valid_cyc[$];
  int          fv_cyc[$];
  logic [15:0] fv_x[$], fv_y[$], fv_z[$];
  logic        fv_g[$];
  int          to_cyc[$];
  int          bad_start = 0;

  int checks = 0;
  int errors = 0;

  // I2C master model and output monitor: sample DUT first, then drive.
  initial begin : bfm
    int         cnt;
    bit         pend;
    bit         s;
    logic [7:0] a;
    logic [7:0] cur;
    cnt = 0; pend = 0; cur = '0;
    i2c_ready = 1'b1; i2c_data_valid = 1'b0; i2c_data = '0;
    forever begin
      @(negedge clk);
      s = i2c_start;
      a = i2c_reg_addr;
      if (s && !i2c_ready) bad_start++;
      if (frame_valid) begin
        fv_cyc.push_back(cyc); fv_x.push_back(axis_x); fv_y.push_back(axis_y);
        fv_z.push_back(axis_z); fv_g.push_back(frame_is_gyro);
      end
      if (timeout_err) to_cyc.push_back(cyc);
      i2c_data_valid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          i2c_data_valid = 1'b1;
          i2c_data       = mem[cur];
          i2c_ready      = 1'b1;
          pend           = 0;
          valid_cyc.push_back(cyc);
        end else begin
          i2c_ready = 1'b0;
        end
      end
      if (s) begin
        start_cyc.push_back(cyc);
        start_addr.push_back(a);
        if (start_cyc.size() - 1 != withhold_idx) begin
          pend = 1; cnt = lat; cur = a;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        sel;
    logic        toggle;
    logic [47:0] bytes;
    logic [7:0]  base;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } vec_t;

  vec_t vecs [3];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n0, f0, v0, t0, k, prev_first;
    vecs[0] = '{sel:1'b0, toggle:1'b0, bytes:48'h1234_FFFE_4000, base:8'h3B,
                x:16'h1234, y:16'hFFFE, z:16'h4000};
    vecs[1] = '{sel:1'b1, toggle:1'b1, bytes:48'h8000_7FFF_0001, base:8'h43,
                x:16'h8000, y:16'h7FFF, z:16'h0001};
    vecs[2] = '{sel:1'b0, toggle:1'b0, bytes:48'hA55A_0000_C33C, base:8'h3B,
                x:16'hA55A, y:16'h0000, z:16'hC33C};
    for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
    prev_first = 0;

    // Reset state
    reset = 1'b0; enable = 1'b0; sel_gyro = 1'b0;
    repeat (3) step();
    check("rst_addr", 32'(i2c_reg_addr), 32'h3B);
    check("rst_start", 32'(i2c_start), 0);
    check("rst_axes", {axis_x, axis_y | axis_z}, 0);
    check("rst_flags", {28'd0, frame_valid, busy, timeout_err, overrun}, 0);
    check("rst_gyro", 32'(frame_is_gyro), 0);
    reset = 1'b1;
    repeat (2) step();

    // Table-driven frames
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 6; j++) mem[vecs[i].base + 8'(j)] = vecs[i].bytes[47 - 8*j -: 8];
      sel_gyro = vecs[i].sel;
      n0 = start_cyc.size(); f0 = fv_cyc.size(); v0 = valid_cyc.size();
      if (i == 0) enable = 1'b1;
      k = 0;
      while (fv_cyc.size() == f0 && k < 500) begin
        step(); k++;
        if (vecs[i].toggle && start_cyc.size() >= n0 + 2) sel_gyro = 1'b0;
      end
      check($sformatf("frame%0d_done", i), 32'(fv_cyc.size() > f0), 1);
      for (int j = 0; j < 6; j++)
        check($sformatf("frame%0d_addr%0d", i, j), 32'(start_addr[n0+j]), 32'(vecs[i].base + 8'(j)));
      for (int j = 0; j < 5; j++)
        check($sformatf("frame%0d_reissue%0d", i, j), start_cyc[n0+j+1], valid_cyc[v0+j] + 1);
      check($sformatf("frame%0d_fv_latency", i), fv_cyc[f0], valid_cyc[v0+5] + 1);
      check($sformatf("frame%0d_x", i), 32'(fv_x[f0]), 32'(vecs[i].x));
      check($sformatf("frame%0d_y", i), 32'(fv_y[f0]), 32'(vecs[i].y));
      check($sformatf("frame%0d_z", i), 32'(fv_z[f0]), 32'(vecs[i].z));
      check($sformatf("frame%0d_gyro", i), 32'(fv_g[f0]), 32'(vecs[i].sel));
      if (i > 0) check($sformatf("frame%0d_period", i), start_cyc[n0] - prev_first, SP);
      prev_first = start_cyc[n0];
      $display("frame %0d: base=%h x=%h y=%h z=%h gyro=%0d first_start=%0d",
               i, start_addr[n0], fv_x[f0], fv_y[f0], fv_z[f0], fv_g[f0], start_cyc[n0]);
    end
    step();
    check("fv_single_pulse", fv_cyc.size(), 3);
    check("no_overrun", 32'(overrun), 0);

    // Timeout: third read of the next frame is never answered
    n0 = start_cyc.size(); f0 = fv_cyc.size(); t0 = to_cyc.size();
    withhold_idx = n0 + 2;
    k = 0;
    while (to_cyc.size() == t0 && k < 400) begin step(); k++; end
    check("timeout_seen", 32'(to_cyc.size() > t0), 1);
    check("timeout_cycle", to_cyc[t0], start_cyc[n0+2] + TO);
    repeat (3) step();
    withhold_idx = -1;
    check("timeout_single", to_cyc.size(), t0 + 1);
    check("timeout_no_fv", fv_cyc.size(), f0);
    check("timeout_axes_x", 32'(axis_x), 32'(vecs[2].x));
    check("timeout_axes_z", 32'(axis_z), 32'(vecs[2].z));
    check("timeout_idle_busy", 32'(busy), 0);
    $display("timeout: third start at %0d, timeout_err at %0d", start_cyc[n0+2], to_cyc[t0]);

    // Overrun: slow master stretches the frame past one period
    lat = 40;
    f0 = fv_cyc.size();
    k = 0;
    while (fv_cyc.size() == f0 && k < 700) begin step(); k++; end
    check("slow_frame_done", 32'(fv_cyc.size() > f0), 1);
    check("slow_frame_x", 32'(fv_x[f0]), 32'(vecs[2].x));
    check("overrun_set", 32'(overrun), 1);
    lat = 10;
    f0 = fv_cyc.size();
    k = 0;
    while (fv_cyc.size() == f0 && k < 600) begin step(); k++; end
    check("after_overrun_frame", 32'(fv_cyc.size() > f0), 1);
    check("overrun_sticky", 32'(overrun), 1);
    $display("overrun: overrun=%0d after slow frame", overrun);

    // Abort: drop enable while waiting for a byte
    lat = 20;
    n0 = start_cyc.size();
    k = 0;
    while (start_cyc.size() == n0 && k < 400) begin step(); k++; end
    check("abort_start_seen", 32'(start_cyc.size() > n0), 1);
    step();
    check("abort_wait_busy", 32'(busy), 1);
    enable = 1'b0;
    f0 = fv_cyc.size(); t0 = to_cyc.size();
    step();
    check("abort_idle_next", 32'(busy), 0);
    repeat (300) step();
    check("abort_no_start", start_cyc.size(), n0 + 1);
    check("abort_no_fv", fv_cyc.size(), f0);
    check("abort_no_timeout", to_cyc.size(), t0);
    check("abort_axes_y", 32'(axis_y), 32'(vecs[2].y));
    $display("abort: starts=%0d frames=%0d after enable drop", start_cyc.size(), fv_cyc.size());

    // Asynchronous reset mid-frame
    lat = 10;
    sel_gyro = 1'b1;
    enable = 1'b1;
    n0 = start_cyc.size();
    k = 0;
    while (start_cyc.size() < n0 + 2 && k < 300) begin step(); k++; end
    check("prereset_addr", 32'(i2c_reg_addr), 32'h44);
    reset = 1'b0;
    #1;
    check("areset_start", 32'(i2c_start), 0);
    check("areset_addr", 32'(i2c_reg_addr), 32'h3B);
    check("areset_axes", {axis_x, axis_y | axis_z}, 0);
    check("areset_flags", {27'd0, frame_is_gyro, frame_valid, busy, timeout_err, overrun}, 0);
    $display("reset: addr=%h busy=%0d overrun=%0d", i2c_reg_addr, busy, overrun);
    enable = 1'b0;
    repeat (3) step();

    check("start_while_not_ready", bad_start, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
